// File: rtl/br_resolve_pkg.sv
// Shared encodings and helpers for the D-stage branch resolver.
package br_resolve_pkg;

  localparam int unsigned StallCntW = 8;

  // br_op encodings; 6 and 7 are invalid and resolve not-taken.
  localparam logic [2:0] OpBeq  = 3'd0;
  localparam logic [2:0] OpBne  = 3'd1;
  localparam logic [2:0] OpBlez = 3'd2;
  localparam logic [2:0] OpBgtz = 3'd3;
  localparam logic [2:0] OpBltz = 3'd4;
  localparam logic [2:0] OpBgez = 3'd5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic op_needs_rs(input logic [2:0] op);
    return (op <= OpBgez);
  endfunction

  function automatic logic op_needs_rt(input logic [2:0] op);
    return (op == OpBeq) || (op == OpBne);
  endfunction

  // pc + 4 + (sext(imm) << 2), wrapping silently at 2^32.
  function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [15:0] imm);
    return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/br_resolve_if.sv
// Pipeline-side bundle between the D stage and the branch resolver.
interface br_resolve_if;
  import br_resolve_pkg::*;

  logic                 req_valid;
  logic [2:0]           br_op;
  logic [31:0]          rs_val;
  logic [31:0]          rt_val;
  logic                 rs_ready;
  logic                 rt_ready;
  logic [31:0]          pc_d;
  logic [15:0]          imm16;
  logic                 flush;
  logic                 stall;
  logic                 resolved;
  logic                 taken;
  logic [31:0]          target;
  logic [StallCntW-1:0] stall_cnt;

  modport master (
    output req_valid, br_op, rs_val, rt_val, rs_ready, rt_ready, pc_d, imm16, flush,
    input  stall, resolved, taken, target, stall_cnt
  );

  modport slave (
    input  req_valid, br_op, rs_val, rt_val, rs_ready, rt_ready, pc_d, imm16, flush,
    output stall, resolved, taken, target, stall_cnt
  );

endinterface

// File: rtl/br_cond.sv
// Branch condition evaluation; purely combinational.
module br_cond
  import br_resolve_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic        cond_o
);

  logic rs_neg;
  logic rs_zero;

  assign rs_neg  = rs_i[31];
  assign rs_zero = (rs_i == 32'd0);

  // Decode the comparison selected by op_i.
  always_comb begin
    cond_o = 1'b0;
    case (op_i)
      OpBeq:   cond_o = (rs_i == rt_i);
      OpBne:   cond_o = (rs_i != rt_i);
      OpBlez:  cond_o = rs_neg | rs_zero;
      OpBgtz:  cond_o = ~rs_neg & ~rs_zero;
      OpBltz:  cond_o = rs_neg;
      OpBgez:  cond_o = ~rs_neg;
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/br_resolve.sv
// D-stage branch resolver: waits for forwarded operands, then pulses the outcome.
module br_resolve
  import br_resolve_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  br_resolve_if.slave br_io
);

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [31:0]          pc_q, pc_d;
  logic [15:0]          imm_q, imm_d;
  logic                 taken_q, taken_d;
  logic [StallCntW-1:0] cnt_q, cnt_d;

  logic [2:0] op_sel;
  logic       ready;
  logic       cond;
  logic       accept;
  logic       stall;
  logic       resolved;

  // In WAIT the latched op governs; otherwise the incoming request does.
  assign op_sel = (state_q == StWait) ? op_q : br_io.br_op;
  assign ready  = (~op_needs_rs(op_sel) | br_io.rs_ready) &
                  (~op_needs_rt(op_sel) | br_io.rt_ready);
  assign accept = (state_q != StWait) & br_io.req_valid;

  br_cond u_cond (
    .op_i  (op_sel),
    .rs_i  (br_io.rs_val),
    .rt_i  (br_io.rt_val),
    .cond_o(cond)
  );

  // Stall is masked during reset so the front end is never frozen by a reset-time request.
  assign stall = ~reset & ((state_q == StWait) | (accept & ~ready));

  // Next-state, request latching and outcome capture; flush overrides everything.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    taken_d = 1'b0;
    if (br_io.flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (br_io.req_valid) begin
            op_d  = br_io.br_op;
            pc_d  = br_io.pc_d;
            imm_d = br_io.imm16;
            if (ready) begin
              state_d = StDone;
              taken_d = cond;
            end else begin
              state_d = StWait;
            end
          end else begin
            state_d = StIdle;
          end
        end
        StWait: begin
          if (ready) begin
            state_d = StDone;
            taken_d = cond;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {StallCntW{1'b1}})) begin
      cnt_d = cnt_q + StallCntW'(1);
    end
  end

  // State and latched fields, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= 3'd0;
      pc_q    <= 32'd0;
      imm_q   <= 16'd0;
      taken_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outcome fields read zero outside the resolved pulse.
  assign resolved        = (state_q == StDone);
  assign br_io.resolved  = resolved;
  assign br_io.taken     = resolved & taken_q;
  assign br_io.target    = resolved ? br_target(pc_q, imm_q) : 32'd0;
  assign br_io.stall     = stall;
  assign br_io.stall_cnt = cnt_q;

endmodule

// File: tb/tb_br_resolve.sv
// Self-checking bench for br_resolve; expected outcomes queued at request time.
module tb_br_resolve;
  import br_resolve_pkg::*;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  br_resolve_if bif();

  br_resolve dut (
    .clk  (clk),
    .reset(reset),
    .br_io(bif.slave)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned exp_cnt = 0;
  exp_t        exp_q[$];
  exp_t        e;

  task automatic idle_inputs();
    bif.req_valid = 1'b0;
    bif.flush     = 1'b0;
    bif.br_op     = 3'd0;
    bif.rs_val    = 32'd0;
    bif.rt_val    = 32'd0;
    bif.rs_ready  = 1'b1;
    bif.rt_ready  = 1'b1;
    bif.pc_d      = 32'd0;
    bif.imm16     = 16'd0;
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] pc, input logic [15:0] imm,
                           input logic rs_rdy, input logic rt_rdy);
    bif.req_valid = 1'b1;
    bif.br_op     = op;
    bif.rs_val    = rs;
    bif.rt_val    = rt;
    bif.pc_d      = pc;
    bif.imm16     = imm;
    bif.rs_ready  = rs_rdy;
    bif.rt_ready  = rt_rdy;
  endtask

  task automatic test_reset();
    idle_inputs();
    drive_req(OpBeq, 32'd1, 32'd2, 32'h40, 16'h1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (bif.stall !== 1'b0) begin
      n_err++; $display("FAIL reset_stall: got %b want 0", bif.stall);
    end
    n_vec++;
    if ({bif.resolved, bif.taken, bif.target, bif.stall_cnt} !== 42'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got res=%b tk=%b tgt=%h cnt=%0d want all 0",
               bif.resolved, bif.taken, bif.target, bif.stall_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_beq();
    @(negedge clk);
    drive_req(OpBeq, 32'h5, 32'h5, 32'h3000, 16'h0004, 1'b1, 1'b1);
    exp_q.push_back('{taken: 1'b1, target: 32'h3014});
    #1;
    n_vec++;
    if (bif.stall !== 1'b0) begin
      n_err++; $display("FAIL beq_stall: got %b want 0", bif.stall);
    end
    @(negedge clk);
    n_vec++;
    if (bif.resolved !== 1'b1) begin
      n_err++; $display("FAIL beq_resolved: got %b want 1", bif.resolved);
    end else begin
      e = exp_q.pop_front();
      n_vec++;
      if ({bif.taken, bif.target} !== {e.taken, e.target}) begin
        n_err++;
        $display("FAIL beq_outcome: got %b/%h want %b/%h", bif.taken, bif.target, e.taken, e.target);
      end
    end
    idle_inputs();
    @(negedge clk);
    n_vec++;
    if ({bif.resolved, bif.taken, bif.target} !== 34'd0) begin
      n_err++;
      $display("FAIL beq_after_pulse: got %b/%b/%h want 0/0/0", bif.resolved, bif.taken, bif.target);
    end
  endtask

  // One-cycle request followed by an outcome check; name tags the comparison.
  task automatic test_single(input string name, input logic [2:0] op, input logic [31:0] rs,
                             input logic [31:0] rt, input logic [31:0] pc, input logic [15:0] imm,
                             input logic rdy, input logic exp_tk, input logic [31:0] exp_tgt);
    @(negedge clk);
    drive_req(op, rs, rt, pc, imm, rdy, rdy);
    exp_q.push_back('{taken: exp_tk, target: exp_tgt});
    @(negedge clk);
    n_vec++;
    if (bif.resolved !== 1'b1) begin
      n_err++; $display("FAIL %s resolved: got %b want 1", name, bif.resolved);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      n_vec++;
      if ({bif.taken, bif.target} !== {e.taken, e.target}) begin
        n_err++;
        $display("FAIL %s outcome: got %b/%h want %b/%h", name, bif.taken, bif.target,
                 e.taken, e.target);
      end
    end
    idle_inputs();
  endtask

  task automatic test_cond_table();
    logic [2:0]  t_op[12]  = '{OpBeq, OpBne, OpBlez, OpBlez, OpBgtz, OpBgtz, OpBltz, OpBltz,
                               OpBgez, OpBgez, 3'd6, 3'd7};
    logic [31:0] t_rs[12]  = '{32'd7, 32'd9, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 32'h8000_0000,
                               32'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'd0};
    logic [31:0] t_rt[12]  = '{32'd8, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                               32'd0, 32'd0, 32'd0};
    logic        t_exp[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                               1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      // Invalid ops need no operands, so the last one resolves even with nothing ready.
      test_single($sformatf("cond_%0d", i), t_op[i], t_rs[i], t_rt[i], 32'h100 * i, 16'h0,
                  (i != 11), t_exp[i], 32'h100 * i + 32'd4);
    end
  endtask

  // rs_ready is low for the request cycle and the first WAIT cycle; the WAIT cycle in which
  // it rises still stalls, giving three stall cycles.
  task automatic test_bgtz_wait();
    @(negedge clk);
    drive_req(OpBgtz, 32'h8000_0000, 32'd0, 32'h1000, 16'h0010, 1'b0, 1'b1);
    exp_q.push_back('{taken: 1'b0, target: 32'h1044});
    for (int c = 0; c < 3; c++) begin
      if (c == 2) bif.rs_ready = 1'b1;
      #1;
      n_vec++;
      if (bif.stall !== 1'b1 || bif.resolved !== 1'b0) begin
        n_err++;
        $display("FAIL bgtz_wait_%0d: got stall=%b res=%b want 1/0", c, bif.stall, bif.resolved);
      end
      exp_cnt++;
      @(negedge clk);
      bif.req_valid = 1'b0;
    end
    n_vec++;
    if (bif.resolved !== 1'b1) begin
      n_err++; $display("FAIL bgtz_resolved: got %b want 1", bif.resolved);
    end else begin
      e = exp_q.pop_front();
      n_vec++;
      if ({bif.taken, bif.target} !== {e.taken, e.target}) begin
        n_err++;
        $display("FAIL bgtz_outcome: got %b/%h want %b/%h", bif.taken, bif.target, e.taken, e.target);
      end
    end
    n_vec++;
    if (bif.stall_cnt !== 8'(exp_cnt)) begin
      n_err++; $display("FAIL bgtz_stall_cnt: got %0d want %0d", bif.stall_cnt, exp_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_flush_kill();
    @(negedge clk);
    drive_req(OpBeq, 32'd3, 32'd3, 32'h500, 16'h1, 1'b1, 1'b0);
    exp_cnt++;
    @(negedge clk);
    bif.req_valid = 1'b0;
    bif.rt_ready  = 1'b1;
    bif.flush     = 1'b1;
    exp_cnt++;
    @(negedge clk);
    bif.flush = 1'b0;
    #1;
    n_vec++;
    if (bif.resolved !== 1'b0 || bif.stall !== 1'b0) begin
      n_err++;
      $display("FAIL flush_kill: got res=%b stall=%b want 0/0", bif.resolved, bif.stall);
    end
    n_vec++;
    if (bif.stall_cnt !== 8'(exp_cnt)) begin
      n_err++; $display("FAIL flush_stall_cnt: got %0d want %0d", bif.stall_cnt, exp_cnt);
    end
    @(negedge clk);
    n_vec++;
    if (bif.resolved !== 1'b0) begin
      n_err++; $display("FAIL flush_no_pulse: got %b want 0", bif.resolved);
    end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    drive_req(OpBeq, 32'd0, 32'd0, 32'h0, 16'h0, 1'b1, 1'b0);
    @(negedge clk);
    bif.req_valid = 1'b0;
    repeat (300) @(negedge clk);
    n_vec++;
    if (bif.stall_cnt !== 8'd255 || bif.stall !== 1'b1) begin
      n_err++;
      $display("FAIL saturate: got cnt=%0d stall=%b want 255/1", bif.stall_cnt, bif.stall);
    end
    bif.flush = 1'b1;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_kill();
    @(negedge clk);
    drive_req(OpBgtz, 32'd1, 32'd0, 32'h800, 16'h2, 1'b0, 1'b1);
    @(negedge clk);
    bif.req_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({bif.resolved, bif.taken, bif.target, bif.stall, bif.stall_cnt} !== 43'd0) begin
      n_err++;
      $display("FAIL reset_mid_wait: got res=%b tk=%b tgt=%h stall=%b cnt=%0d want all 0",
               bif.resolved, bif.taken, bif.target, bif.stall, bif.stall_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    exp_cnt = 0;
    // Also kill a branch in DONE: taken/target must clear without a clock edge.
    drive_req(OpBne, 32'd1, 32'd2, 32'h600, 16'h3, 1'b1, 1'b1);
    @(negedge clk);
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({bif.resolved, bif.taken, bif.target} !== 34'd0) begin
      n_err++;
      $display("FAIL reset_in_done: got %b/%b/%h want 0/0/0", bif.resolved, bif.taken, bif.target);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    reset = 1'b0;
    drive_req(OpBlez, 32'd0, 32'd0, 32'h2000, 16'h0008, 1'b1, 1'b0);
    exp_q.push_back('{taken: 1'b1, target: 32'h2024});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_vec++;
      if (bif.resolved !== 1'b1) begin
        n_err++; $display("FAIL b2b_resolved_%0d: got %b want 1", k, bif.resolved);
        void'(exp_q.pop_front());
      end else begin
        e = exp_q.pop_front();
        n_vec++;
        if ({bif.taken, bif.target} !== {e.taken, e.target}) begin
          n_err++;
          $display("FAIL b2b_outcome_%0d: got %b/%h want %b/%h", k, bif.taken, bif.target,
                   e.taken, e.target);
        end
      end
      if (k == 0) begin
        drive_req(OpBlez, 32'd0, 32'd0, 32'h2100, 16'hFFFE, 1'b1, 1'b0);
        exp_q.push_back('{taken: 1'b1, target: 32'h20FC});
      end else begin
        idle_inputs();
      end
    end
    @(negedge clk);
    n_vec++;
    if (bif.resolved !== 1'b0 || bif.stall_cnt !== 8'(exp_cnt)) begin
      n_err++;
      $display("FAIL b2b_end: got res=%b cnt=%0d want 0/%0d", bif.resolved, bif.stall_cnt, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_single("bne_neg_imm", OpBne, 32'd1, 32'd2, 32'h3000, 16'hFFFF, 1'b1, 1'b1, 32'h3000);
    test_single("bgez_wrap", OpBgez, 32'd0, 32'd0, 32'hFFFF_FFFC, 16'h0001, 1'b1, 1'b1,
                32'h0000_0004);
    test_cond_table();
    test_bgtz_wait();
    test_flush_kill();
    test_saturate();
    test_reset_kill();
    test_back_to_back();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
